// File: rtl/primitive_assembler_pkg.sv
// primitive_assembler_pkg: primitive type codes, output kind codes and FSM states shared by the assembler
package primitive_assembler_pkg;
  localparam logic [3:0] TYPE_POINTS     = 4'd0;
  localparam logic [3:0] TYPE_LINES      = 4'd1;
  localparam logic [3:0] TYPE_LINE_STRIP = 4'd2;
  localparam logic [3:0] TYPE_TRIANGLES  = 4'd3;
  localparam logic [3:0] TYPE_TRI_STRIP  = 4'd4;
  localparam logic [3:0] TYPE_TRI_FAN    = 4'd5;
  localparam logic [1:0] KIND_POINT = 2'd0;
  localparam logic [1:0] KIND_LINE  = 2'd1;
  localparam logic [1:0] KIND_TRI   = 2'd2;
  localparam logic [1:0] KIND_DRAW  = 2'd3;
  typedef enum logic {ST_IDLE, ST_ASSEMBLE} state_t;
  function automatic logic type_valid(input logic [3:0] t);
    return t <= TYPE_TRI_FAN;
  endfunction
endpackage

// File: rtl/primitive_assembler_fifo.sv
// primitive_assembler_fifo: show-ahead FIFO of assembled primitives
//   clk/rst_n: clock, async active-low reset
//   push/din: write side; pop: read side; dout: head entry (show-ahead)
//   count/full/empty: occupancy, all decoded from registered state
module primitive_assembler_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 98
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_comb begin
    mem_d   = mem_q;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) mem_d[wr_q] = din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/primitive_assembler.sv
// primitive_assembler: groups decode's vertex events into points, lines and triangles for the rasterizer
//   CLK/RESET_N: clock, async active-low reset
//   Vertex/NewVertex/StartPrimitive/PrimitiveType/EndPrimitive/Draw: one-hot event stream from decode
//   Stall: back-pressure to decode (FIFO full)
//   PRIM_VALID/PRIM_READY/PRIM_KIND/PRIM_V0..2: primitive handshake toward rasterizer
//   PRIM_ERR: sticky protocol error
module primitive_assembler
  import primitive_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int VERT_W     = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [VERT_W-1:0] Vertex,
  input  logic              NewVertex,
  input  logic              StartPrimitive,
  input  logic [3:0]        PrimitiveType,
  input  logic              EndPrimitive,
  input  logic              Draw,
  output logic              Stall,
  output logic              PRIM_VALID,
  input  logic              PRIM_READY,
  output logic [1:0]        PRIM_KIND,
  output logic [VERT_W-1:0] PRIM_V0,
  output logic [VERT_W-1:0] PRIM_V1,
  output logic [VERT_W-1:0] PRIM_V2,
  output logic              PRIM_ERR
);
  localparam int ENTRY_W = 2 + 3*VERT_W;
  state_t              state_q, state_d;
  logic [3:0]          type_q, type_d;
  logic [1:0]          vcnt_q, vcnt_d;
  logic [VERT_W-1:0]   win0_q, win0_d, win1_q, win1_d, pivot_q, pivot_d;
  logic                parity_q, parity_d, err_q, err_d;
  logic                emit, accept, multi, full, empty;
  logic [1:0]          kind;
  logic [VERT_W-1:0]   e0, e1, e2;
  logic [ENTRY_W-1:0]  head;
  logic [FIFO_AW:0]    fifo_count;
  primitive_assembler_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .W(ENTRY_W)) u_fifo (
    .clk(CLK), .rst_n(RESET_N), .push(emit), .din({kind, e0, e1, e2}),
    .pop(PRIM_READY), .dout(head), .count(fifo_count), .full(full), .empty(empty)
  );
  // Stall comes only from the registered count, so a pop this cycle frees space next cycle
  assign Stall      = fifo_count == (FIFO_AW+1)'(FIFO_DEPTH);
  assign accept     = ~Stall & ~full;
  assign multi      = (StartPrimitive & (EndPrimitive | NewVertex | Draw)) | (EndPrimitive & (NewVertex | Draw)) | (NewVertex & Draw);
  assign PRIM_VALID = ~empty;
  assign PRIM_KIND  = empty ? 2'd0 : head[ENTRY_W-1 -: 2];
  assign PRIM_V0    = empty ? '0 : head[3*VERT_W-1 -: VERT_W];
  assign PRIM_V1    = empty ? '0 : head[2*VERT_W-1 -: VERT_W];
  assign PRIM_V2    = empty ? '0 : head[VERT_W-1:0];
  assign PRIM_ERR   = err_q;
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    vcnt_d   = vcnt_q;
    win0_d   = win0_q;
    win1_d   = win1_q;
    pivot_d  = pivot_q;
    parity_d = parity_q;
    err_d    = err_q | (accept & multi);
    emit     = 1'b0;
    kind     = KIND_POINT;
    e0       = '0;
    e1       = '0;
    e2       = '0;
    if (accept) begin
      if (StartPrimitive) begin
        // a start inside a primitive implicitly ends it; an invalid type leaves us idle
        state_d  = type_valid(PrimitiveType) ? ST_ASSEMBLE : ST_IDLE;
        err_d    = err_d | ~type_valid(PrimitiveType);
        type_d   = PrimitiveType;
        vcnt_d   = '0;
        parity_d = 1'b0;
      end else if (EndPrimitive) begin
        state_d = ST_IDLE;
      end else if (NewVertex && state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else if (NewVertex) begin
        // win1 always holds the previous vertex, win0 the one before it
        win0_d = win1_q;
        win1_d = Vertex;
        if (vcnt_q == 2'd0) pivot_d = Vertex;
        vcnt_d = (vcnt_q == 2'd2) ? 2'd2 : vcnt_q + 2'd1;
        e2     = Vertex;
        case (type_q)
          TYPE_POINTS: begin
            emit = 1'b1;
            e0   = Vertex;
            e2   = '0;
          end
          TYPE_LINES: if (vcnt_q == 2'd1) begin
            emit   = 1'b1;
            kind   = KIND_LINE;
            e0     = win1_q;
            e1     = Vertex;
            e2     = '0;
            vcnt_d = '0;
          end
          TYPE_LINE_STRIP: if (vcnt_q != 2'd0) begin
            emit = 1'b1;
            kind = KIND_LINE;
            e0   = win1_q;
            e1   = Vertex;
            e2   = '0;
          end
          TYPE_TRIANGLES: if (vcnt_q == 2'd2) begin
            emit   = 1'b1;
            kind   = KIND_TRI;
            e0     = win0_q;
            e1     = win1_q;
            vcnt_d = '0;
          end
          TYPE_TRI_STRIP: if (vcnt_q == 2'd2) begin
            emit     = 1'b1;
            kind     = KIND_TRI;
            e0       = parity_q ? win1_q : win0_q;
            e1       = parity_q ? win0_q : win1_q;
            parity_d = ~parity_q;
          end
          TYPE_TRI_FAN: if (vcnt_q == 2'd2) begin
            emit = 1'b1;
            kind = KIND_TRI;
            e0   = pivot_q;
            e1   = win1_q;
          end
          default: emit = 1'b0;
        endcase
        if (!emit) e2 = '0;
      end else if (Draw) begin
        emit = 1'b1;
        kind = KIND_DRAW;
      end
    end
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      type_q   <= '0;
      vcnt_q   <= '0;
      win0_q   <= '0;
      win1_q   <= '0;
      pivot_q  <= '0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      vcnt_q   <= vcnt_d;
      win0_q   <= win0_d;
      win1_q   <= win1_d;
      pivot_q  <= pivot_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
endmodule

// File: tb/tb_primitive_assembler.sv
// tb_primitive_assembler: directed self-checking bench for primitive_assembler
module tb_primitive_assembler;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] Vertex = '0;
  logic        NewVertex = 1'b0, StartPrimitive = 1'b0, EndPrimitive = 1'b0, Draw = 1'b0;
  logic [3:0]  PrimitiveType = '0;
  logic        PRIM_READY = 1'b0;
  logic        Stall, PRIM_VALID, PRIM_ERR;
  logic [1:0]  PRIM_KIND;
  logic [31:0] PRIM_V0, PRIM_V1, PRIM_V2;
  logic [97:0] obs;
  int n_cmp = 0, n_bad = 0;
  localparam logic [31:0] A = 32'h000A000A, B = 32'h000B000B, C = 32'h000C000C, D = 32'h000D000D, E = 32'h000E000E;
  localparam logic [31:0] PV = 32'h00500050;
  always #5 CLK = ~CLK;
  assign obs = {PRIM_KIND, PRIM_V0, PRIM_V1, PRIM_V2};
  primitive_assembler dut (
    .CLK(CLK), .RESET_N(RESET_N), .Vertex(Vertex), .NewVertex(NewVertex),
    .StartPrimitive(StartPrimitive), .PrimitiveType(PrimitiveType), .EndPrimitive(EndPrimitive),
    .Draw(Draw), .Stall(Stall), .PRIM_VALID(PRIM_VALID), .PRIM_READY(PRIM_READY),
    .PRIM_KIND(PRIM_KIND), .PRIM_V0(PRIM_V0), .PRIM_V1(PRIM_V1), .PRIM_V2(PRIM_V2), .PRIM_ERR(PRIM_ERR)
  );
  function automatic logic [97:0] prim(input logic [1:0] k, input logic [31:0] a, b, c);
    return {k, a, b, c};
  endfunction
  // drives one event at a negedge, waits (bounded) for Stall low, lets one posedge consume it
  task automatic ev(input logic s, e, n, d, input logic [3:0] t, input logic [31:0] v);
    int k = 0;
    StartPrimitive = s; EndPrimitive = e; NewVertex = n; Draw = d; PrimitiveType = t; Vertex = v;
    while (Stall && k < 50) begin @(negedge CLK); k++; end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL ev_timeout: Stall=%b required 0", Stall);
    end
    @(posedge CLK); @(negedge CLK);
    StartPrimitive = 0; EndPrimitive = 0; NewVertex = 0; Draw = 0; PrimitiveType = '0; Vertex = '0;
  endtask
  task automatic start(input logic [3:0] t); ev(1, 0, 0, 0, t, '0); endtask
  task automatic vert(input logic [31:0] v); ev(0, 0, 1, 0, '0, v); endtask
  task automatic endp(); ev(0, 1, 0, 0, '0, '0); endtask
  // samples the head then pops it for one cycle; comparison stays with the caller
  task automatic pop_one(output logic vld, output logic [97:0] got);
    vld = PRIM_VALID; got = obs;
    PRIM_READY = 1; @(posedge CLK); @(negedge CLK); PRIM_READY = 0;
  endtask
  task automatic test_reset();
    RESET_N = 0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({Stall, PRIM_VALID, PRIM_ERR, obs} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h required 0", {Stall, PRIM_VALID, PRIM_ERR, obs});
    end
    RESET_N = 1;
    @(negedge CLK);
  endtask
  task automatic test_triangles();
    PRIM_READY = 1;
    start(4'd3); vert(32'h00010001); vert(32'h00020002);
    n_cmp++;
    if (PRIM_VALID !== 1'b0) begin n_bad++; $display("FAIL tri_early_valid: got %b required 0", PRIM_VALID); end
    vert(32'h00030003);
    n_cmp++;
    if (PRIM_VALID !== 1'b1 || obs !== prim(2, 32'h00010001, 32'h00020002, 32'h00030003)) begin
      n_bad++; $display("FAIL tri_emit: got v=%b %h required v=1 %h", PRIM_VALID, obs, prim(2, 32'h00010001, 32'h00020002, 32'h00030003));
    end
    @(posedge CLK); @(negedge CLK);
    n_cmp++;
    if (PRIM_VALID !== 1'b0) begin n_bad++; $display("FAIL tri_popped: got %b required 0", PRIM_VALID); end
    endp();
    PRIM_READY = 0;
  endtask
  task automatic test_strip_fan();
    logic [97:0] ex[$];
    logic vld;
    logic [97:0] got;
    start(4'd4); vert(A); vert(B); vert(C); vert(D); vert(E); endp();
    ex = '{prim(2, A, B, C), prim(2, C, B, D), prim(2, C, D, E)};
    foreach (ex[i]) begin
      pop_one(vld, got);
      n_cmp++;
      if (!vld || got !== ex[i]) begin n_bad++; $display("FAIL strip_%0d: got v=%b %h required %h", i, vld, got, ex[i]); end
    end
    n_cmp++;
    if (PRIM_VALID !== 1'b0) begin n_bad++; $display("FAIL strip_extra: got valid %b required 0", PRIM_VALID); end
    start(4'd5); vert(PV); vert(B); vert(C); vert(D); endp();
    ex = '{prim(2, PV, B, C), prim(2, PV, C, D)};
    foreach (ex[i]) begin
      pop_one(vld, got);
      n_cmp++;
      if (!vld || got !== ex[i]) begin n_bad++; $display("FAIL fan_%0d: got v=%b %h required %h", i, vld, got, ex[i]); end
    end
    n_cmp++;
    if (PRIM_VALID !== 1'b0) begin n_bad++; $display("FAIL fan_extra: got valid %b required 0", PRIM_VALID); end
  endtask
  task automatic test_back_pressure();
    logic vld;
    logic [97:0] got;
    start(4'd0);
    for (int i = 1; i <= 4; i++) vert(32'(i));
    n_cmp++;
    if (Stall !== 1'b1) begin n_bad++; $display("FAIL bp_stall_full: got %b required 1", Stall); end
    NewVertex = 1; Vertex = 32'd5;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (Stall !== 1'b1) begin n_bad++; $display("FAIL bp_stall_held: got %b required 1", Stall); end
    pop_one(vld, got);
    n_cmp++;
    if (!vld || got !== prim(0, 32'd1, 0, 0)) begin n_bad++; $display("FAIL bp_point_1: got v=%b %h required %h", vld, got, prim(0, 32'd1, 0, 0)); end
    @(posedge CLK); @(negedge CLK);
    NewVertex = 0; Vertex = '0;
    n_cmp++;
    if (Stall !== 1'b1) begin n_bad++; $display("FAIL bp_refill: got %b required 1", Stall); end
    for (int i = 2; i <= 5; i++) begin
      pop_one(vld, got);
      n_cmp++;
      if (!vld || got !== prim(0, 32'(i), 0, 0)) begin n_bad++; $display("FAIL bp_point_%0d: got v=%b %h required %h", i, vld, got, prim(0, 32'(i), 0, 0)); end
    end
    n_cmp++;
    if (PRIM_VALID !== 1'b0 || Stall !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got valid=%b stall=%b required 0 0", PRIM_VALID, Stall); end
    endp();
  endtask
  task automatic test_lines_end();
    logic vld;
    logic [97:0] got;
    start(4'd1); vert(A); vert(B); vert(C); endp();
    pop_one(vld, got);
    n_cmp++;
    if (!vld || got !== prim(1, A, B, 0)) begin n_bad++; $display("FAIL line_0: got v=%b %h required %h", vld, got, prim(1, A, B, 0)); end
    n_cmp++;
    if (PRIM_VALID !== 1'b0) begin n_bad++; $display("FAIL line_extra: got valid %b required 0", PRIM_VALID); end
    n_cmp++;
    if (PRIM_ERR !== 1'b0) begin n_bad++; $display("FAIL line_err: got %b required 0", PRIM_ERR); end
  endtask
  task automatic test_draw_err();
    logic [97:0] ex[$];
    logic vld;
    logic [97:0] got;
    start(4'd3); vert(A); vert(B); vert(C); vert(D); vert(E); vert(PV);
    ev(0, 0, 0, 1, '0, '0);
    ex = '{prim(2, A, B, C), prim(2, D, E, PV), prim(3, 0, 0, 0)};
    foreach (ex[i]) begin
      pop_one(vld, got);
      n_cmp++;
      if (!vld || got !== ex[i]) begin n_bad++; $display("FAIL draw_%0d: got v=%b %h required %h", i, vld, got, ex[i]); end
    end
    n_cmp++;
    if (PRIM_ERR !== 1'b0) begin n_bad++; $display("FAIL draw_err_clean: got %b required 0", PRIM_ERR); end
    start(4'd9);
    n_cmp++;
    if (PRIM_ERR !== 1'b1) begin n_bad++; $display("FAIL bad_type_err: got %b required 1", PRIM_ERR); end
  endtask
  task automatic test_reset_mid();
    logic vld;
    logic [97:0] got;
    start(4'd3); vert(A); vert(B); vert(C); vert(D); vert(E); vert(PV); vert(32'h00070007);
    n_cmp++;
    if (PRIM_VALID !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b required 1", PRIM_VALID); end
    RESET_N = 0;
    #1;
    n_cmp++;
    if ({PRIM_VALID, Stall, PRIM_ERR, obs} !== '0) begin
      n_bad++; $display("FAIL rst_async: got %h required 0", {PRIM_VALID, Stall, PRIM_ERR, obs});
    end
    @(negedge CLK); RESET_N = 1; @(negedge CLK);
    start(4'd3); vert(32'h00080008); vert(32'h00090009); vert(32'h000A0001);
    pop_one(vld, got);
    n_cmp++;
    if (!vld || got !== prim(2, 32'h00080008, 32'h00090009, 32'h000A0001)) begin
      n_bad++; $display("FAIL rst_clean_tri: got v=%b %h required %h", vld, got, prim(2, 32'h00080008, 32'h00090009, 32'h000A0001));
    end
    n_cmp++;
    if (PRIM_VALID !== 1'b0 || PRIM_ERR !== 1'b0) begin n_bad++; $display("FAIL rst_after: got valid=%b err=%b required 0 0", PRIM_VALID, PRIM_ERR); end
  endtask
  initial begin
    test_reset();
    test_triangles();
    test_strip_fan();
    test_back_pressure();
    test_lines_end();
    test_draw_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
